// File: rtl/hamming_pkg.sv
// Shared SEC-DED Hamming helpers: code sizing, encode, decode and classification.
package hamming_pkg;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned MAX_R = 7;
    localparam int unsigned MAX_N = MAX_W + MAX_R;

    typedef enum logic [1:0] {CLEAN, SEC, DED} err_class_t;
    typedef enum logic {NORMAL, FAULT} state_t;

    typedef struct packed {
        logic [MAX_R-1:0] check;
        logic             ovp;
    } enc_t;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic [MAX_R-1:0] syn;
        err_class_t       cls;
    } dec_t;

    // Smallest r with 2^r >= width + r + 1
    function automatic int unsigned hamming_r(input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i <= MAX_R; i++) begin
            if (r == 0 && (32'd1 << i) >= width + i + 1) r = i;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int unsigned v);
        return (v & (v - 1)) == 0;
    endfunction

    // Data is zero-extended to MAX_W; check bits above r stay zero.
    function automatic enc_t hamming_encode(input logic [MAX_W-1:0] data,
                                            input int unsigned width);
        enc_t        e;
        int unsigned n;
        int unsigned d;
        e = '0;
        d = 0;
        n = width + hamming_r(width);
        for (int unsigned pos = 1; pos <= MAX_N; pos++) begin
            if (pos <= n && !is_pow2(pos)) begin
                for (int unsigned i = 0; i < MAX_R; i++) begin
                    if (data[d[5:0]] && ((pos >> i) & 1) != 0)
                        e.check[i[2:0]] = ~e.check[i[2:0]];
                end
                d++;
            end
        end
        e.ovp = ^{data, e.check};
        return e;
    endfunction

    function automatic dec_t hamming_decode(input logic [MAX_W-1:0] data,
                                            input logic [MAX_R-1:0] check,
                                            input logic             ovp,
                                            input int unsigned      width);
        dec_t        r;
        enc_t        e;
        int unsigned n;
        int unsigned d;
        int unsigned s;
        logic        pm;
        e      = hamming_encode(data, width);
        r.data = data;
        r.syn  = e.check ^ check;
        pm     = ^{data, check, ovp};
        n      = width + hamming_r(width);
        s      = 32'(r.syn);
        d      = 0;
        // Flip the data bit sitting at the syndrome position; check-bit
        // positions and out-of-range syndromes leave the data alone.
        for (int unsigned pos = 1; pos <= MAX_N; pos++) begin
            if (pos <= n && !is_pow2(pos)) begin
                if (pm && pos == s) r.data[d[5:0]] = ~r.data[d[5:0]];
                d++;
            end
        end
        if (!pm)
            r.cls = (s == 0) ? CLEAN : DED;
        else
            r.cls = (s <= n) ? SEC : DED;
        return r;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SEC-DED decoder for any Hamming-protected register.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned R     = hamming_r(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [R-1:0]     check,
    input  logic             ovp,
    output logic [WIDTH-1:0] corrected,
    output logic [R-1:0]     syndrome,
    output err_class_t       err_class
);

    logic [MAX_W-1:0] data_ext;
    logic [MAX_R-1:0] check_ext;
    dec_t             dec;
    logic             unused_dec;

    // Widen stored word to package width and run the decode function
    always_comb begin
        data_ext             = '0;
        data_ext[WIDTH-1:0]  = data;
        check_ext            = '0;
        check_ext[R-1:0]     = check;
        dec = hamming_decode(data_ext, check_ext, ovp, WIDTH);
    end

    assign corrected  = dec.data[WIDTH-1:0];
    assign syndrome   = dec.syn[R-1:0];
    assign err_class  = dec.cls;
    assign unused_dec = ^{dec.data, dec.syn};

endmodule

// File: rtl/hamming_counter_secded.sv
// Up/down counter whose state is held as a SEC-DED protected codeword.
module hamming_counter_secded
    import hamming_pkg::*;
#(
    parameter  int unsigned WIDTH    = 16,
    parameter  bit          SCRUB    = 1'b1,
    parameter  int unsigned ERRCNT_W = 8,
    localparam int unsigned R        = hamming_r(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                up,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_value,
    input  logic                clear_err,
    output logic [WIDTH-1:0]    counter,
    output logic                sec_err,
    output logic                ded_err,
    output logic [R-1:0]        syndrome,
    output logic [ERRCNT_W-1:0] err_count
);

    logic [WIDTH-1:0] data_q;
    logic [R-1:0]     check_q;
    logic             ovp_q;
    state_t           state_q;

    logic [WIDTH-1:0] corrected;
    logic [R-1:0]     syn_c;
    err_class_t       err_class;

    logic             write;
    logic [WIDTH-1:0] next_data;
    logic [MAX_W-1:0] next_ext;
    enc_t             next_enc;
    logic             unused_enc;
    logic             sec_now;

    hamming_secded_dec #(.WIDTH(WIDTH)) u_dec (
        .data      (data_q),
        .check     (check_q),
        .ovp       (ovp_q),
        .corrected (corrected),
        .syndrome  (syn_c),
        .err_class (err_class)
    );

    assign counter    = (state_q == FAULT) ? data_q : corrected;
    assign sec_now    = (state_q == NORMAL) && (err_class == SEC);
    assign unused_enc = ^next_enc.check;

    // Select the next stored value: load, count, scrub or hold
    always_comb begin
        write     = 1'b0;
        next_data = data_q;
        if (load) begin
            write     = 1'b1;
            next_data = load_value;
        end else if (state_q == NORMAL && err_class != DED) begin
            if (enable) begin
                write     = 1'b1;
                next_data = up ? corrected + 1'b1 : corrected - 1'b1;
            end else if (SCRUB && err_class == SEC) begin
                write     = 1'b1;
                next_data = corrected;
            end
        end
    end

    // Re-encode every write into a fresh, clean codeword
    always_comb begin
        next_ext            = '0;
        next_ext[WIDTH-1:0] = next_data;
        next_enc            = hamming_encode(next_ext, WIDTH);
    end

    // Protected storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            check_q <= '0;
            ovp_q   <= 1'b0;
        end else if (write) begin
            data_q  <= next_data;
            check_q <= next_enc.check[R-1:0];
            ovp_q   <= next_enc.ovp;
        end
    end

    // Fault FSM with registered error status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= NORMAL;
            ded_err   <= 1'b0;
            sec_err   <= 1'b0;
            syndrome  <= '0;
            err_count <= '0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (!load && err_class == DED) begin
                        state_q <= FAULT;
                        ded_err <= 1'b1;
                    end
                end
                FAULT: begin
                    if (load) begin
                        state_q <= NORMAL;
                        ded_err <= 1'b0;
                    end
                end
                default: state_q <= NORMAL;
            endcase
            if (state_q == NORMAL && err_class != CLEAN)
                syndrome <= syn_c;
            if (clear_err) begin
                sec_err   <= 1'b0;
                err_count <= '0;
            end else begin
                sec_err <= sec_now;
                if (sec_now && err_count != '1)
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_counter_secded.sv
// Self-checking bench for hamming_counter_secded (SCRUB=1 and SCRUB=0 instances).
module tb_hamming_counter_secded;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, up, load, clear_err;
    logic [15:0] load_value;
    logic [15:0] counter, counter0;
    logic        sec_err, sec_err0, ded_err, ded_err0;
    logic [4:0]  syndrome, syndrome0;
    logic [7:0]  err_count, err_count0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] m_val;
    int unsigned m_err;

    hamming_counter_secded #(.WIDTH(16), .SCRUB(1'b1), .ERRCNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear_err(clear_err), .counter(counter),
        .sec_err(sec_err), .ded_err(ded_err), .syndrome(syndrome),
        .err_count(err_count)
    );

    hamming_counter_secded #(.WIDTH(16), .SCRUB(1'b0), .ERRCNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear_err(clear_err), .counter(counter0),
        .sec_err(sec_err0), .ded_err(ded_err0), .syndrome(syndrome0),
        .err_count(err_count0)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Codeword position of data bit k: k-th non-power-of-two position from 1
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned seen = 0;
        for (int unsigned p = 1; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == k) return p;
                seen++;
            end
        end
        return 0;
    endfunction

    // Check bits are the XOR of the positions of all set data bits
    function automatic logic [4:0] model_check(input logic [15:0] v);
        logic [4:0]  c = '0;
        int unsigned p;
        for (int unsigned k = 0; k < 16; k++) begin
            p = data_pos(k);
            if (v[k]) c ^= p[4:0];
        end
        return c;
    endfunction

    function automatic logic model_ovp(input logic [15:0] v);
        return ^{v, model_check(v)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 0; up = 0; load = 0; clear_err = 0; load_value = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (counter !== 16'h0 || sec_err !== 1'b0 || ded_err !== 1'b0 ||
            syndrome !== 5'h0 || err_count !== 8'h0) begin
            n_fail++;
            $display("FAIL reset: counter=%h sec=%b ded=%b syn=%h cnt=%h, required all zero",
                     counter, sec_err, ded_err, syndrome, err_count);
        end
        n_checks++;
        if (counter0 !== 16'h0 || sec_err0 !== 1'b0 || ded_err0 !== 1'b0 || err_count0 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_noscrub: counter=%h sec=%b ded=%b cnt=%h, required all zero",
                     counter0, sec_err0, ded_err0, err_count0);
        end
        rst = 1'b0;
        m_val = 16'h0;
        m_err = 0;
    endtask

    task automatic test_count();
        enable = 1; up = 1;
        repeat (10) tick();
        n_checks++;
        if (counter !== 16'd10 || sec_err !== 1'b0 || ded_err !== 1'b0) begin
            n_fail++;
            $display("FAIL count_up: counter=%0d sec=%b ded=%b, required 10 0 0", counter, sec_err, ded_err);
        end
        up = 0;
        repeat (3) tick();
        n_checks++;
        if (counter !== 16'd7) begin
            n_fail++;
            $display("FAIL count_down: counter=%0d, required 7", counter);
        end
        enable = 0;
        m_val = 16'd7;
    endtask

    task automatic test_random_count();
        for (int i = 0; i < 60; i++) begin
            enable     = 1'($urandom_range(0, 1));
            up         = 1'($urandom_range(0, 1));
            load       = ($urandom_range(0, 7) == 0);
            load_value = 16'($urandom);
            tick();
            if (load)        m_val = load_value;
            else if (enable) m_val = up ? m_val + 16'd1 : m_val - 16'd1;
            n_checks++;
            if (counter !== m_val) begin
                n_fail++;
                $display("FAIL random_count[%0d]: counter=%h, required %h", i, counter, m_val);
            end
        end
        enable = 0; load = 0;
    endtask

    task automatic test_sec_data();
        load = 1; load_value = 16'h0132;
        tick();
        load = 0; m_val = 16'h0132;
        force dut.data_q = 16'h013A;
        release dut.data_q;
        #1;
        n_checks++;
        if (counter !== 16'h0132) begin
            n_fail++;
            $display("FAIL sec_same_cycle: counter=%h, required 0132", counter);
        end
        tick();
        m_err++;
        n_checks++;
        if (sec_err !== 1'b1 || err_count !== 8'(m_err) || syndrome !== 5'(data_pos(3))) begin
            n_fail++;
            $display("FAIL sec_flags: sec=%b cnt=%0d syn=%0d, required 1 %0d %0d",
                     sec_err, err_count, syndrome, m_err, data_pos(3));
        end
        n_checks++;
        if (dut.data_q !== m_val || dut.check_q !== model_check(m_val) || dut.ovp_q !== model_ovp(m_val)) begin
            n_fail++;
            $display("FAIL scrub_storage: data=%h chk=%h ovp=%b, required %h %h %b",
                     dut.data_q, dut.check_q, dut.ovp_q, m_val, model_check(m_val), model_ovp(m_val));
        end
        tick();
        n_checks++;
        if (sec_err !== 1'b0 || counter !== m_val) begin
            n_fail++;
            $display("FAIL sec_after_scrub: sec=%b counter=%h, required 0 %h", sec_err, counter, m_val);
        end
    endtask

    task automatic test_sec_random();
        int unsigned k;
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 15);
            force dut.data_q = m_val ^ (16'd1 << k);
            release dut.data_q;
            #1;
            n_checks++;
            if (counter !== m_val) begin
                n_fail++;
                $display("FAIL sec_rand_counter bit%0d: counter=%h, required %h", k, counter, m_val);
            end
            tick();
            m_err++;
            n_checks++;
            if (sec_err !== 1'b1 || syndrome !== 5'(data_pos(k)) || err_count !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL sec_rand_flags bit%0d: sec=%b syn=%0d cnt=%0d, required 1 %0d %0d",
                         k, sec_err, syndrome, err_count, data_pos(k), m_err);
            end
        end
        tick();
    endtask

    task automatic test_check_ovp();
        force dut.check_q = model_check(m_val) ^ 5'b00010;
        release dut.check_q;
        #1;
        n_checks++;
        if (counter !== m_val) begin
            n_fail++;
            $display("FAIL check_flip_counter: counter=%h, required %h", counter, m_val);
        end
        tick();
        m_err++;
        n_checks++;
        if (sec_err !== 1'b1 || syndrome !== 5'd2 || err_count !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL check_flip_flags: sec=%b syn=%0d cnt=%0d, required 1 2 %0d", sec_err, syndrome, err_count, m_err);
        end
        tick();
        force dut.ovp_q = ~model_ovp(m_val);
        release dut.ovp_q;
        tick();
        m_err++;
        n_checks++;
        if (sec_err !== 1'b1 || syndrome !== 5'd0 || counter !== m_val || err_count !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL ovp_flip: sec=%b syn=%0d counter=%h cnt=%0d, required 1 0 %h %0d",
                     sec_err, syndrome, counter, err_count, m_val, m_err);
        end
        tick();
    endtask

    task automatic test_ded();
        logic [15:0] bad;
        bad = m_val ^ 16'h0028;
        force dut.data_q = bad;
        release dut.data_q;
        tick();
        n_checks++;
        if (ded_err !== 1'b1 || sec_err !== 1'b0 || err_count !== 8'(m_err) ||
            syndrome !== 5'(data_pos(3) ^ data_pos(5))) begin
            n_fail++;
            $display("FAIL ded_detect: ded=%b sec=%b cnt=%0d syn=%0d, required 1 0 %0d %0d",
                     ded_err, sec_err, err_count, syndrome, m_err, data_pos(3) ^ data_pos(5));
        end
        enable = 1; up = 1;
        repeat (3) tick();
        n_checks++;
        if (counter !== bad || ded_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ded_freeze: counter=%h ded=%b, required %h 1", counter, ded_err, bad);
        end
        enable = 0; load = 1; load_value = 16'h00FF;
        tick();
        load = 0; m_val = 16'h00FF;
        n_checks++;
        if (ded_err !== 1'b0 || counter !== 16'h00FF) begin
            n_fail++;
            $display("FAIL ded_recover: ded=%b counter=%h, required 0 00ff", ded_err, counter);
        end
        enable = 1; up = 0;
        tick();
        enable = 0; m_val = 16'h00FE;
        n_checks++;
        if (counter !== m_val || sec_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_recover_count: counter=%h sec=%b, required %h 0", counter, sec_err, m_val);
        end
    endtask

    task automatic test_wrap();
        load = 1; load_value = 16'hFFFF;
        tick();
        load = 0; enable = 1; up = 1;
        tick();
        n_checks++;
        if (counter !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_up: counter=%h, required 0000", counter);
        end
        up = 0;
        tick();
        n_checks++;
        if (counter !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_down: counter=%h, required ffff", counter);
        end
        enable = 0; m_val = 16'hFFFF;
    endtask

    task automatic test_noscrub();
        int unsigned k;
        int unsigned exp_cnt;
        load = 1; load_value = 16'h1234;
        tick();
        load = 0; m_val = 16'h1234;
        k = $urandom_range(0, 15);
        force dut0.data_q = 16'h1234 ^ (16'd1 << k);
        release dut0.data_q;
        #1;
        n_checks++;
        if (counter0 !== 16'h1234) begin
            n_fail++;
            $display("FAIL noscrub_counter: counter=%h, required 1234", counter0);
        end
        for (int unsigned i = 1; i <= 300; i++) begin
            tick();
            exp_cnt = (i > 255) ? 255 : i;
            n_checks++;
            if (sec_err0 !== 1'b1 || err_count0 !== 8'(exp_cnt) || syndrome0 !== 5'(data_pos(k))) begin
                n_fail++;
                $display("FAIL noscrub_persist[%0d]: sec=%b cnt=%0d syn=%0d, required 1 %0d %0d",
                         i, sec_err0, err_count0, syndrome0, exp_cnt, data_pos(k));
            end
        end
        clear_err = 1;
        tick();
        clear_err = 0; m_err = 0;
        n_checks++;
        if (err_count0 !== 8'd0 || sec_err0 !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_wins: cnt0=%0d sec0=%b cnt=%0d, required 0 0 0", err_count0, sec_err0, err_count);
        end
        tick();
        n_checks++;
        if (err_count0 !== 8'd1 || sec_err0 !== 1'b1) begin
            n_fail++;
            $display("FAIL noscrub_recount: cnt=%0d sec=%b, required 1 1", err_count0, sec_err0);
        end
        enable = 1; up = 1;
        tick();
        enable = 0; m_val = 16'h1235;
        n_checks++;
        if (counter0 !== 16'h1235 || counter !== m_val) begin
            n_fail++;
            $display("FAIL noscrub_overwrite: counter0=%h counter=%h, required 1235 %h", counter0, counter, m_val);
        end
        tick();
        n_checks++;
        if (sec_err0 !== 1'b0 || err_count0 !== 8'd2) begin
            n_fail++;
            $display("FAIL noscrub_clean: sec=%b cnt=%0d, required 0 2", sec_err0, err_count0);
        end
    endtask

    task automatic test_async_reset();
        force dut.data_q = m_val ^ 16'h0001;
        release dut.data_q;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (counter !== 16'h0 || sec_err !== 1'b0 || err_count !== 8'h0 || ded_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: counter=%h sec=%b cnt=%0d ded=%b, required 0 0 0 0",
                     counter, sec_err, err_count, ded_err);
        end
        tick();
        n_checks++;
        if (sec_err !== 1'b0 || counter !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_discard_scrub: sec=%b counter=%h, required 0 0", sec_err, counter);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_count();
        test_random_count();
        test_sec_data();
        test_sec_random();
        test_check_ovp();
        test_ded();
        test_wrap();
        test_noscrub();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
